matrix_feeder: RTL and testbench

- Upstream neighbour of the input skew stage. Accepts one MATRIX_SIZE x MATRIX_SIZE operand matrix row by row over a valid/ready handshake and buffers it in full.
- Replays the matrix column by column as MATRIX_SIZE-wide vectors, together with the enable that drives the skew shift registers.
- After the last column, drives MATRIX_SIZE-1 zero vectors with enable high. This flushes the deepest skew lane so every element reaches the array.

---
 rtl/matrix_pkg.sv | 15 +
 rtl/matrix_buffer.sv | 36 +++
 rtl/matrix_feeder.sv | 88 ++++++++
 tb/tb_matrix_feeder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix feeder.
package matrix_pkg;

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_buffer.sv
// Square register file: one full-row write port, one full-column read port.
module matrix_buffer
  import matrix_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  localparam int CW = cnt_w(MATRIX_SIZE),
  localparam int W  = DATA_SIZE * MATRIX_SIZE
) (
  input  logic          clk,
  input  logic          we,
  input  logic [CW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [CW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [DATA_SIZE-1:0] mem [MATRIX_SIZE][MATRIX_SIZE];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int j = 0; j < MATRIX_SIZE; j++) begin
        mem[waddr][j] <= wdata[j*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < MATRIX_SIZE; i++) begin
      rdata[i*DATA_SIZE +: DATA_SIZE] = mem[i][raddr];
    end
  end

endmodule

// File: rtl/matrix_feeder.sv
// Buffers a matrix row-wise, replays it column-wise, then flushes the skew.
module matrix_feeder
  import matrix_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  localparam int W = DATA_SIZE * MATRIX_SIZE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_row,
  input  logic         out_ready,
  output logic         out_enable,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         done
);

  localparam int CW = cnt_w(MATRIX_SIZE);
  localparam logic [CW-1:0] LAST = CW'(MATRIX_SIZE - 1);
  localparam logic [CW-1:0] FLAST =
    CW'((MATRIX_SIZE > 1) ? MATRIX_SIZE - 2 : 0);

  feeder_state_t state, state_nxt;
  logic [CW-1:0] row_cnt, col_cnt, flush_cnt;
  logic [W-1:0]  col_data;
  logic          xfer;

  matrix_buffer #(
    .MATRIX_SIZE (MATRIX_SIZE),
    .DATA_SIZE   (DATA_SIZE)
  ) u_buf (
    .clk   (clk),
    .we    (xfer),
    .waddr (row_cnt),
    .wdata (in_row),
    .raddr (col_cnt),
    .rdata (col_data)
  );

  assign xfer = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:
        if (xfer && row_cnt == LAST)
          state_nxt = STREAM;
      STREAM:
        if (out_enable && col_cnt == LAST)
          state_nxt = (MATRIX_SIZE == 1) ? DONE : FLUSH;
      FLUSH:
        if (out_enable && flush_cnt == FLAST)
          state_nxt = DONE;
      DONE:
        state_nxt = LOAD;
      default:
        state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      row_cnt   <= '0;
      col_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (xfer)
        row_cnt <= (row_cnt == LAST) ? '0 : row_cnt + CW'(1);
      if (state == STREAM && out_enable)
        col_cnt <= (col_cnt == LAST) ? '0 : col_cnt + CW'(1);
      if (state == FLUSH && out_enable)
        flush_cnt <= (flush_cnt == FLAST) ? '0 : flush_cnt + CW'(1);
    end
  end

  // Reset gates in_ready so nothing is accepted while it is held.
  assign in_ready   = reset & (state == LOAD);
  assign busy       = (state == STREAM) | (state == FLUSH);
  assign out_enable = busy & out_ready;
  assign done       = (state == DONE);
  assign out_data   = (state == STREAM && out_ready) ? col_data : '0;

endmodule

// File: tb/tb_matrix_feeder.sv
// Directed, table-driven bench for matrix_feeder at sizes 2, 4 and 1.
module tb_matrix_feeder;

  typedef struct {
    logic        iv;
    logic [63:0] row;
    logic        ordy;
    logic        erdy;
    logic        een;
    logic [63:0] edata;
    logic        ebusy;
    logic        edone;
  } vec_t;

  logic clk;
  logic reset;

  logic        iv2, rdy2, ordy2, en2, busy2, done2;
  logic [63:0] row2, data2;
  logic         iv4, rdy4, ordy4, en4, busy4, done4;
  logic [127:0] row4, data4;
  logic        iv1, rdy1, ordy1, en1, busy1, done1;
  logic [31:0] row1, data1;

  int checks = 0;
  int errors = 0;

  matrix_feeder #(.MATRIX_SIZE(2), .DATA_SIZE(32)) dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(rdy2),
    .in_row(row2), .out_ready(ordy2), .out_enable(en2),
    .out_data(data2), .busy(busy2), .done(done2)
  );

  matrix_feeder #(.MATRIX_SIZE(4), .DATA_SIZE(32)) dut4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(rdy4),
    .in_row(row4), .out_ready(ordy4), .out_enable(en4),
    .out_data(data4), .busy(busy4), .done(done4)
  );

  matrix_feeder #(.MATRIX_SIZE(1), .DATA_SIZE(32)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(rdy1),
    .in_row(row1), .out_ready(ordy1), .out_enable(en1),
    .out_data(data1), .busy(busy1), .done(done1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pr(input int a, input int b);
    return {b[31:0], a[31:0]};
  endfunction

  function automatic vec_t mk(input logic iv, input logic [63:0] row,
                              input logic ordy, input logic erdy,
                              input logic een, input logic [63:0] ed,
                              input logic eb, input logic edn);
    vec_t v;
    v.iv = iv; v.row = row; v.ordy = ordy; v.erdy = erdy;
    v.een = een; v.edata = ed; v.ebusy = eb; v.edone = edn;
    return v;
  endfunction

  task automatic step2(input vec_t v, input string nm);
    @(negedge clk);
    iv2 = v.iv; row2 = v.row; ordy2 = v.ordy;
    #1;
    chk({nm, ".in_ready"}, 128'(rdy2), 128'(v.erdy));
    chk({nm, ".out_enable"}, 128'(en2), 128'(v.een));
    chk({nm, ".out_data"}, 128'(data2), 128'(v.edata));
    chk({nm, ".busy"}, 128'(busy2), 128'(v.ebusy));
    chk({nm, ".done"}, 128'(done2), 128'(v.edone));
  endtask

  vec_t tbl[$];
  logic [63:0] junk;
  logic [127:0] exp4;

  initial begin
    junk = pr(32'hEE, 32'hFF);
    reset = 0;
    iv2 = 0; row2 = '0; ordy2 = 0;
    iv4 = 0; row4 = '0; ordy4 = 0;
    iv1 = 0; row1 = '0; ordy1 = 0;
    #1;
    chk("rst.in_ready", 128'(rdy2), 128'(0));
    chk("rst.out_enable", 128'(en2), 128'(0));
    chk("rst.out_data", 128'(data2), 128'(0));
    chk("rst.busy", 128'(busy2), 128'(0));
    chk("rst.done", 128'(done2), 128'(0));
    @(negedge clk);
    reset = 1;

    // basic: rows [1,2],[3,4]
    tbl.push_back(mk(1, pr(1, 2), 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, pr(3, 4), 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, pr(1, 3), 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, pr(2, 4), 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    // backpressure, including a stall inside the flush
    tbl.push_back(mk(1, pr(1, 2), 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, pr(3, 4), 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, pr(1, 3), 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, pr(2, 4), 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    // input gating: junk rows offered while streaming
    tbl.push_back(mk(1, pr(1, 2), 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, pr(3, 4), 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, junk, 1, 0, 1, pr(1, 3), 1, 0));
    tbl.push_back(mk(1, junk, 1, 0, 1, pr(2, 4), 1, 0));
    tbl.push_back(mk(1, junk, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, junk, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, pr(5, 6), 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, pr(7, 8), 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, junk, 1, 0, 1, pr(5, 7), 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, pr(6, 8), 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));

    foreach (tbl[k]) step2(tbl[k], $sformatf("vec%0d", k));

    // reset mid-stream
    step2(mk(1, pr(1, 2), 1, 1, 0, 0, 0, 0), "mr.load0");
    step2(mk(1, pr(3, 4), 1, 1, 0, 0, 0, 0), "mr.load1");
    step2(mk(0, 0, 1, 0, 1, pr(1, 3), 1, 0), "mr.beat0");
    @(negedge clk);
    ordy2 = 1;
    reset = 0;
    #1;
    chk("mr.async.in_ready", 128'(rdy2), 128'(0));
    chk("mr.async.out_enable", 128'(en2), 128'(0));
    chk("mr.async.out_data", 128'(data2), 128'(0));
    chk("mr.async.busy", 128'(busy2), 128'(0));
    chk("mr.async.done", 128'(done2), 128'(0));
    #2 reset = 1;
    step2(mk(0, 0, 1, 1, 0, 0, 0, 0), "mr.idle0");
    step2(mk(0, 0, 1, 1, 0, 0, 0, 0), "mr.idle1");
    step2(mk(1, pr(9, 10), 1, 1, 0, 0, 0, 0), "mr.reload0");
    step2(mk(1, pr(11, 12), 1, 1, 0, 0, 0, 0), "mr.reload1");
    step2(mk(0, 0, 1, 0, 1, pr(9, 11), 1, 0), "mr.col0");
    step2(mk(0, 0, 1, 0, 1, pr(10, 12), 1, 0), "mr.col1");
    step2(mk(0, 0, 1, 0, 1, 0, 1, 0), "mr.flush");
    step2(mk(0, 0, 1, 0, 0, 0, 0, 1), "mr.done");

    // MATRIX_SIZE=4, element (r,c) = r*4+c+1
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      iv4 = 1; ordy4 = 1;
      for (int c = 0; c < 4; c++) row4[c*32 +: 32] = 32'(r*4 + c + 1);
      #1;
      chk($sformatf("m4.load%0d.in_ready", r), 128'(rdy4), 128'(1));
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      iv4 = 0;
      for (int i = 0; i < 4; i++) exp4[i*32 +: 32] = 32'(i*4 + c + 1);
      #1;
      chk($sformatf("m4.col%0d.en", c), 128'(en4), 128'(1));
      chk($sformatf("m4.col%0d.data", c), data4, exp4);
    end
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      #1;
      chk($sformatf("m4.flush%0d.en", f), 128'(en4), 128'(1));
      chk($sformatf("m4.flush%0d.data", f), data4, 128'(0));
      chk($sformatf("m4.flush%0d.done", f), 128'(done4), 128'(0));
    end
    @(negedge clk);
    #1;
    chk("m4.done", 128'(done4), 128'(1));
    chk("m4.done.en", 128'(en4), 128'(0));
    @(negedge clk);
    #1;
    chk("m4.after.in_ready", 128'(rdy4), 128'(1));
    chk("m4.after.done", 128'(done4), 128'(0));

    // MATRIX_SIZE=1: no flush beats
    @(negedge clk);
    iv1 = 1; row1 = 32'd42; ordy1 = 1;
    #1;
    chk("m1.load.in_ready", 128'(rdy1), 128'(1));
    @(negedge clk);
    iv1 = 0;
    #1;
    chk("m1.beat.en", 128'(en1), 128'(1));
    chk("m1.beat.data", 128'(data1), 128'(42));
    @(negedge clk);
    #1;
    chk("m1.done", 128'(done1), 128'(1));
    chk("m1.done.en", 128'(en1), 128'(0));
    chk("m1.done.data", 128'(data1), 128'(0));
    @(negedge clk);
    #1;
    chk("m1.after.in_ready", 128'(rdy1), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
